// File: rtl/store_buffer_pkg.sv
// Shared types and default sizes for the store buffer slice.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEF = 8;
  localparam int SB_ADDR_W    = 32;
  localparam int SB_DATA_W    = 32;

  // One buffered store: byte address, lane-aligned data and byte enables.
  typedef struct packed {
    logic [SB_ADDR_W-1:0]   addr;
    logic [SB_DATA_W-1:0]   data;
    logic [SB_DATA_W/8-1:0] wstrb;
  } sb_entry_t;

  // Drain state machine towards the data cache.
  typedef enum logic [1:0] {
    SB_IDLE,
    SB_REQ,
    SB_WAIT
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// Data-cache write channel driven by the store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);

  logic                data_req;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic [DATA_W/8-1:0] data_wstrb;
  logic                data_addr_ok;
  logic                data_data_ok;

  modport master (
    output data_req, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-first search over the live window head..tail-1 of the store buffer.
module sb_fwd_match #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic [PTR_W-1:0] head,
  input  logic [PTR_W-1:0] tail,
  input  logic [DEPTH-1:0] match,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [PTR_W-1:0] live;
  logic [IDX_W-1:0] slot;

  // Walk oldest to youngest so the last live match seen (closest to tail) wins.
  always_comb begin
    live = tail - head;
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head[IDX_W-1:0] + IDX_W'(k);
      if ((PTR_W'(k) < live) && match[slot]) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between commit and the data cache: holds stores in program
// order, drains committed ones one at a time and forwards to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = SB_ADDR_W,
  parameter int DATA_W   = SB_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                st_valid,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_wstrb,
  output logic                sb_allowin,
  input  logic                commit_store1_valid,
  input  logic                commit_store2_valid,
  store_buffer_if.master      dcache,
  input  logic [ADDR_W-1:0]   ld_addr,
  output logic                ld_fwd_hit,
  output logic [DATA_W-1:0]   ld_fwd_data,
  output logic [DATA_W/8-1:0] ld_fwd_wstrb,
  output logic                sb_empty
);

  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry a wrap bit above the array index.
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] cmt;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] ncmt;
  logic [PTR_W-1:0] commits;
  logic [PTR_W-1:0] cmt_next;

  sb_entry_t entries [SB_DEPTH];
  sb_entry_t head_entry;

  sb_state_t state;
  logic      req_q;
  logic      alloc;
  logic      pop;

  logic [SB_DEPTH-1:0] addr_match;
  logic                fwd_hit;
  logic [IDX_W-1:0]    fwd_idx;
  logic                unused_ld_lsb;

  assign count      = tail - head;
  assign ncmt       = cmt - head;
  assign sb_allowin = count < PTR_W'(SB_DEPTH);
  assign alloc      = st_valid && sb_allowin && !flush;
  assign commits    = PTR_W'(commit_store1_valid) + PTR_W'(commit_store2_valid);
  assign cmt_next   = cmt + commits;
  assign pop        = ((state == SB_REQ) && dcache.data_addr_ok && dcache.data_data_ok) ||
                      ((state == SB_WAIT) && dcache.data_data_ok);
  assign sb_empty   = (count == '0) && (state == SB_IDLE);

  // Pointer update; a flush rewinds tail to the commit point including this cycle's commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + PTR_W'(pop);
      cmt  <= cmt_next;
      tail <= flush ? cmt_next : tail + PTR_W'(alloc);
    end
  end

  // Entry storage is plain data; liveness comes only from the pointers.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entries[tail[IDX_W-1:0]] <= '{addr: st_addr, data: st_data, wstrb: st_wstrb};
    end
  end

  // Drain FSM: one outstanding cache write, request held until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SB_IDLE;
      req_q <= 1'b0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (ncmt != '0) begin
            state <= SB_REQ;
            req_q <= 1'b1;
          end
        end
        SB_REQ: begin
          if (dcache.data_addr_ok) begin
            state <= dcache.data_data_ok ? SB_IDLE : SB_WAIT;
            req_q <= 1'b0;
          end
        end
        SB_WAIT: begin
          if (dcache.data_data_ok) begin
            state <= SB_IDLE;
          end
        end
        default: begin
          state <= SB_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign head_entry        = entries[head[IDX_W-1:0]];
  assign dcache.data_req   = req_q;
  assign dcache.data_addr  = head_entry.addr;
  assign dcache.data_wdata = head_entry.data;
  assign dcache.data_wstrb = head_entry.wstrb;

  // Word-granular address compare of every slot; liveness is applied by the search.
  always_comb begin
    addr_match = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      addr_match[i] = (entries[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    end
  end

  assign unused_ld_lsb = ^ld_addr[1:0];

  sb_fwd_match #(
    .DEPTH (SB_DEPTH)
  ) u_fwd_match (
    .head  (head),
    .tail  (tail),
    .match (addr_match),
    .hit   (fwd_hit),
    .idx   (fwd_idx)
  );

  assign ld_fwd_hit   = fwd_hit;
  assign ld_fwd_data  = fwd_hit ? entries[fwd_idx].data  : '0;
  assign ld_fwd_wstrb = fwd_hit ? entries[fwd_idx].wstrb : '0;

  a_no_alloc_when_full: assert property (@(posedge clk) disable iff (reset)
    !(st_valid && !sb_allowin));

  a_commit2_needs_commit1: assert property (@(posedge clk) disable iff (reset)
    !(commit_store2_valid && !commit_store1_valid));

  a_commit_within_tail: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, ncmt} + {1'b0, commits}) <= {1'b0, count}));

endmodule
